// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the APB4 slave bridge: FSM state encoding
// and the width of the wait-state timeout counter.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Enough bits to count up to TIMEOUT_CYCLES; never narrower than one bit.
  function automatic int cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter: cleared outside WAIT, counts WAIT cycles, flags the
// last permitted wait cycle. A zero TIMEOUT_CYCLES disables the flag.
module apb_timeout_cnt
  import apb_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      assign expired = enable && (count_reg == LAST);
    end else begin : g_timeout_off
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/apb4_slave_bridge.sv
// APB4 completer that turns each decoded transfer into a one-cycle re/we
// request to a simple slave, waits for slave_rdy (or a timeout) and responds.
module apb4_slave_bridge
  import apb_bridge_pkg::*;
#(
  parameter int              ADDR_WIDTH     = 32,
  parameter int              DATA_WIDTH     = 32,
  parameter longint unsigned BASE_ADDR      = 0,
  parameter longint unsigned WINDOW_BYTES   = 4096,
  parameter int              TIMEOUT_CYCLES = 16,
  localparam int             STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  re,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] sel,
  input  logic                  slave_rdy,
  input  logic [DATA_WIDTH-1:0] rdata
);

  generate
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64))
    begin : g_bad_data_width
      $error("apb4_slave_bridge: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if ((WINDOW_BYTES % longint'(STRB_WIDTH)) != 0) begin : g_bad_window
      $error("apb4_slave_bridge: WINDOW_BYTES must be a multiple of STRB_WIDTH");
    end
  endgenerate

  // Window decode in 65 bits so BASE_ADDR + WINDOW_BYTES cannot wrap.
  localparam logic [64:0]           BASE_EXT  = 65'(BASE_ADDR);
  localparam logic [64:0]           LIMIT_EXT = 65'(BASE_ADDR) + 65'(WINDOW_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_TRUNC = ADDR_WIDTH'(BASE_ADDR);

  state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] prdata_reg;
  logic                  pready_reg, pslverr_reg, re_reg, we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_WIDTH-1:0] sel_reg;
  logic                  write_reg, err_reg;

  logic [64:0] paddr_ext;
  logic        setup, in_window, aligned, req_ok, expired;

  assign paddr_ext = {{(65 - ADDR_WIDTH){1'b0}}, PADDR};
  assign setup     = PSEL && !PENABLE;
  assign in_window = (paddr_ext >= BASE_EXT) && (paddr_ext < LIMIT_EXT);
  assign aligned   = (PADDR & LOW_MASK) == '0;
  assign req_ok    = in_window && aligned;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (state_reg != WAIT),
    .enable (state_reg == WAIT),
    .expired(expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Dropping PSEL while waiting is a master abort: back to IDLE, no response.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (setup) state_next = req_ok ? WAIT : RESP;
      WAIT: begin
        if (!PSEL) begin
          state_next = IDLE;
        end else if (slave_rdy || expired) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      re_reg      <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      sel_reg     <= '0;
      write_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      re_reg      <= 1'b0;
      we_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (setup) begin
            addr_reg  <= (PADDR - BASE_TRUNC) & ~LOW_MASK;
            wdata_reg <= PWDATA;
            sel_reg   <= PWRITE ? PSTRB : {STRB_WIDTH{1'b1}};
            write_reg <= PWRITE;
            err_reg   <= !req_ok;
            re_reg    <= req_ok && !PWRITE;
            we_reg    <= req_ok && PWRITE;
            if (!req_ok) begin
              pready_reg  <= 1'b1;
              pslverr_reg <= 1'b1;
              prdata_reg  <= '0;
            end
          end
        end
        WAIT: begin
          // slave_rdy is checked first so a completion on the last wait
          // cycle beats the timeout.
          if (PSEL && slave_rdy) begin
            pready_reg <= 1'b1;
            err_reg    <= 1'b0;
            prdata_reg <= write_reg ? '0 : rdata;
          end else if (PSEL && expired) begin
            pready_reg  <= 1'b1;
            pslverr_reg <= 1'b1;
            err_reg     <= 1'b1;
            prdata_reg  <= '0;
          end
        end
        default: err_reg <= 1'b0;
      endcase
    end
  end

  assign PRDATA  = prdata_reg;
  assign PREADY  = pready_reg;
  assign PSLVERR = pslverr_reg;
  assign re      = re_reg;
  assign we      = we_reg;
  assign addr    = addr_reg;
  assign wdata   = wdata_reg;
  assign sel     = sel_reg;

endmodule

// File: doc/apb4_slave_bridge.md
APB4_SLAVE_BRIDGE -- requirements
Module: apb4_slave_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width (10..64).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (8,16,32,64); STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first decoded byte address.
REQ-004 SHALL have parameter WINDOW_BYTES, default 4096, decoded window size in bytes.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum WAIT cycles (0 = timeout disabled).
REQ-006 SHALL have ports, in order:
- PCLK  in  1  clock; one clock, all logic on rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- PSEL, PENABLE, PWRITE  in  1 each  APB4 controls.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  STRB_WIDTH  write byte strobes.
- PRDATA  out  DATA_WIDTH  registered read data.
- PREADY, PSLVERR  out  1 each  registered response.
- re, we  out  1 each  one-cycle slave request pulses.
- addr  out  ADDR_WIDTH  latched offset (PADDR - BASE_ADDR), low log2(STRB_WIDTH) bits zero.
- wdata  out  DATA_WIDTH  latched PWDATA.
- sel  out  STRB_WIDTH  byte lanes: latched PSTRB on write, all ones on read.
- slave_rdy  in  1  slave completion (write accepted / rdata valid).
- rdata  in  DATA_WIDTH  slave read data, valid when slave_rdy=1.

Function
REQ-007 SHALL implement states IDLE, WAIT, RESP.
REQ-008 IDLE: on PSEL=1, PENABLE=0 (setup), SHALL latch addr/wdata/sel/direction at the clock edge.
- Request valid: SHALL go to WAIT, with re or we high for exactly the first WAIT cycle.
- Request invalid: SHALL go to RESP with error flag set, no re/we.
REQ-009 Request SHALL be invalid if PADDR outside [BASE_ADDR, BASE_ADDR+WINDOW_BYTES-1], or PADDR low log2(STRB_WIDTH) bits are non-zero.
REQ-010 In IDLE, PENABLE=1 without a prior setup SHALL be ignored: no re/we, no PREADY.
REQ-011 WAIT: slave_rdy SHALL be sampled every cycle, including the re/we cycle; on slave_rdy=1 SHALL go to RESP.
- Read: PRDATA captures rdata.
- Write: PRDATA holds 0.
REQ-012 WAIT: a cycle counter SHALL start at 0 on entry and increment per WAIT cycle.
- Counter = TIMEOUT_CYCLES-1 with slave_rdy=0 and TIMEOUT_CYCLES>0: SHALL go to RESP, error flag set, PRDATA=0.
- Simultaneous slave_rdy=1 and timeout: slave_rdy SHALL win, no error.
REQ-013 RESP: PREADY=1 and PSLVERR=error flag for exactly one cycle; SHALL then go to IDLE.
- PRDATA SHALL hold its value until the next RESP.
REQ-014 PSEL=0 observed in WAIT or RESP (master abort) SHALL return to IDLE next edge.
- No PREADY is issued; any later slave_rdy is ignored.
REQ-015 Minimum latency: setup cycle T0, re/we in T1, slave_rdy in T1, PREADY in T2 (one wait state).
REQ-016 Back-to-back: the setup cycle SHALL coincide with the first IDLE cycle after RESP, with no lost transfer.
REQ-017 PSLVERR SHALL be 0 whenever PREADY=0.

Reset
REQ-018 PRESET=1 SHALL asynchronously force the following, including mid-transfer; no PREADY completes the aborted transfer:
- state = IDLE, counter = 0, error flag = 0
- PREADY, PSLVERR, re, we = 0
- PRDATA, addr, wdata, sel = 0
REQ-019 Outputs SHALL become active from the first rising PCLK after PRESET deasserts.

Structure
REQ-020 A shared package apb_bridge_pkg SHALL hold state_t (IDLE, WAIT, RESP) and a function computing the timeout counter width.
- Counter width = $clog2(TIMEOUT_CYCLES+1), minimum 1.
REQ-021 The timeout counter SHALL be a sub-module apb_timeout_cnt with ports:
- clear
- enable
- expired
REQ-022 Parameters SHALL be checked at elaboration: DATA_WIDTH in the legal set, WINDOW_BYTES a multiple of STRB_WIDTH.

Verification
REQ-023 Write PADDR=0x10, PWDATA=0xA5A5_0001, PSTRB=0b0011, slave_rdy=1 in T1.
- Response: we=1 in T1 only, addr=0x10, sel=0b0011; PREADY=1, PSLVERR=0 in T2.
REQ-024 Read PADDR=0x20, slave_rdy at 3rd WAIT cycle with rdata=0xDEAD_BEEF.
- Response: re=1 for one cycle; PREADY with PRDATA=0xDEAD_BEEF 4 cycles after setup.
REQ-025 Read PADDR=0x2000 (outside window), then PADDR=0x21 (misaligned).
- Response, each: no re/we; PREADY=1, PSLVERR=1 in cycle after setup.
REQ-026 TIMEOUT_CYCLES=16, slave_rdy held 0.
- Response: PREADY=1, PSLVERR=1, PRDATA=0 after exactly 16 WAIT cycles.
- Rerun with slave_rdy=1 on cycle 16: PSLVERR=0.
REQ-027 Back-to-back write 0x0 then read 0x4, plus PRESET pulse during WAIT of a third transfer.
- Both complete, no idle gap beyond REQ-016.
- Reset: immediate IDLE, all outputs 0, no PREADY.
